scarv_cop_cpu_issue: RTL and testbench
======================================

# scarv_cop_cpu_issue

Host-side issue unit for the SCARV coprocessor instruction interface: the CPU end of the request/response protocol whose coprocessor end decodes and executes the 32-bit ISE encodings. It accepts one coprocessor instruction at a time from the CPU pipeline and presents it to the coprocessor with a req/ack handshake. It then waits for the coprocessor response, with a timeout, and holds the status and GPR write-back result until the pipeline consumes it.

## Interface
- TIMEOUT, 255: maximum number of cycles spent in WAIT_RSP before a timeout result is returned. Legal range is 1..255; the counter is 8 bits.
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- pipe_valid  in  1  the pipeline offers an instruction.
- pipe_ready  out  1  the issue unit can accept an instruction.
- pipe_enc  in  32  encoded ISE instruction word.
- pipe_rs1  in  32  GPR rs1 operand value.
- pipe_flush  in  1  cancels an instruction that the coprocessor has not yet acknowledged.
- cpu_insn_req  out  1  request to the coprocessor.
- cpu_insn_ack  in  1  coprocessor accepts the request.
- cpu_insn_enc  out  32  instruction word sent with the request.
- cpu_rs1  out  32  rs1 value sent with the request.
- cop_insn_rsp  in  1  single-cycle response strobe from the coprocessor.
- cop_insn_status  in  3  response status code.
- cop_wen  in  1  response requests a GPR write.
- cop_waddr  in  5  GPR write address.
- cop_wdata  in  32  GPR write data.
- res_valid  out  1  a result is available to the pipeline.
- res_ready  in  1  the pipeline consumes the result.
- res_status  out  3  result status.
- res_wen  out  1  result GPR write enable.
- res_waddr  out  5  result GPR write address.
- res_wdata  out  32  result GPR write data.
- busy  out  1  high in any state other than IDLE.

## Operation
- The state machine has four states: IDLE, REQ, WAIT_RSP and DONE.
- **IDLE**
  - pipe_ready=1.
  - pipe_valid && !pipe_flush: capture pipe_enc and pipe_rs1 into holding registers, then go to REQ.
  - pipe_valid && pipe_flush: the instruction is dropped and the state stays IDLE.
- **REQ**
  - cpu_insn_req=1. cpu_insn_enc and cpu_rs1 are driven from the holding registers and remain stable until ack.
  - ack && rsp in the same cycle: capture the response and go to DONE.
  - ack alone: clear the timer and go to WAIT_RSP.
  - pipe_flush && !ack: drop the request and go to IDLE. No result is produced.
  - ack takes priority over flush.
  - No timeout applies in REQ; the request is never withdrawn except by flush.
- **WAIT_RSP**
  - The timer increments every cycle.
  - rsp: capture status, wen, waddr and wdata, then go to DONE.
  - Timer reaching TIMEOUT without rsp: load status SCARV_COP_INSN_TIMEOUT (3'b111) with wen=0, then go to DONE.
  - If rsp arrives in the same cycle the timer reaches TIMEOUT, rsp wins.
  - pipe_flush is ignored, because the instruction is already committed.
- **DONE**
  - res_valid=1 and the res_* outputs are held stable.
  - res_ready: go to IDLE.
  - pipe_flush is ignored.
- **Spurious inputs:** cop_insn_rsp in IDLE, REQ-without-ack, or DONE is ignored, and so is cpu_insn_ack outside REQ. Neither alters any output.
- **Write-enable masking:** res_wen is forced to 0 whenever res_status != SCARV_COP_INSN_SUCCESS (3'b000), regardless of the value of cop_wen.

## Timing
- **Reset values:** state=IDLE, cpu_insn_req=0, cpu_insn_enc=0, cpu_rs1=0, res_valid=0, res_status=0, res_wen=0, res_waddr=0, res_wdata=0, busy=0, timer=0.
  - pipe_ready is combinational from state, so it is 1 out of reset.
- **Reset mid-operation:** any state returns to IDLE on the next edge and cpu_insn_req drops that edge. A late cop_insn_rsp arriving after reset is ignored.
- **Registered vs combinational outputs:**
  - cpu_insn_req, res_valid and busy decode registered state only.
  - No output depends combinationally on cpu_insn_ack, cop_insn_rsp or res_ready.
- **Minimum latency:**
  - Instruction accepted at edge 0.
  - cpu_insn_req high in cycle 1.
  - ack and rsp in cycle 1 give res_valid in cycle 2.
  - Result consumed in cycle 2 gives pipe_ready in cycle 3.
- **Timeout:** if ack arrives in cycle k and no rsp follows, res_valid rises in cycle k+TIMEOUT+1 with status 3'b111.
- **Throughput:** at most one instruction is outstanding. Back-to-back issue requires at least 3 cycles per instruction.

## Structure
- Status codes SCARV_COP_INSN_SUCCESS and SCARV_COP_INSN_TIMEOUT, together with the state encodings, belong in the shared scarv_cop_common.vh.
- One sub-module: scarv_cop_issue_timer. It is an 8-bit counter with clear and enable inputs and an expired output that compares against TIMEOUT.
- Everything else lives in scarv_cop_cpu_issue.

## Test plan
- **Single-cycle transaction:** pipe_enc=0x1234_5677, rs1=0xDEAD_BEEF. The coprocessor responds with ack and rsp in the same cycle, status 0, wen=1, waddr=5, wdata=0xA5A5_A5A5.
  - Required: cpu_insn_enc/cpu_rs1 match at req.
  - Required: res_valid in cycle 2 with those values.
  - Required: pipe_ready in cycle 3.
- **Ack stall with stability check:** ack is held low for 4 cycles.
  - Required: cpu_insn_req stays 1 and cpu_insn_enc/cpu_rs1 stay stable throughout.
  - Required: rsp 2 cycles after ack yields res_valid one cycle later.
- **Flush vs ack:**
  - Flush in REQ without ack: req drops next cycle, res_valid is never asserted, and pipe_ready returns.
  - Flush in the same cycle as ack: the transaction proceeds normally.
- **Timeout:** TIMEOUT=4, ack then no rsp.
  - Required: res_valid 5 cycles after ack with status 3'b111 and res_wen=0.
  - A later stray rsp is ignored.
- **Error status and backpressure:**
  - rsp with status 3'b010 and cop_wen=1 gives res_wen=0.
  - Hold res_ready low for 6 cycles: res_* stays stable, and a new pipe_valid is not accepted.
- **Reset mid-flight:** assert g_reset in WAIT_RSP.
  - Required: all outputs take their reset values next cycle.
  - Required: a following rsp produces no res_valid.

Source files
------------

// File: rtl/scarv_cop_cpu_issue_pkg.sv
// Shared definitions for the SCARV coprocessor CPU-side issue unit:
// response status codes, FSM state encoding and the write-enable mask helper.
package scarv_cop_cpu_issue_pkg;

    localparam logic [2:0] SCARV_COP_INSN_SUCCESS = 3'b000;
    localparam logic [2:0] SCARV_COP_INSN_TIMEOUT = 3'b111;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StWaitRsp = 2'b10,
        StDone    = 2'b11
    } issue_state_e;

    // A GPR write is only allowed to escape with a successful status.
    function automatic logic mask_wen(input logic [2:0] status, input logic wen);
        return wen && (status == SCARV_COP_INSN_SUCCESS);
    endfunction

endpackage

// File: rtl/scarv_cop_issue_timer.sv
// 8-bit response timer. Cleared when the coprocessor acknowledges a request,
// counts while waiting for the response. expired_o flags the last waiting
// cycle, so the FSM leaves WAIT_RSP after exactly TIMEOUT cycles there.
module scarv_cop_issue_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    logic [7:0] count_q;

    // Counter: clear has priority over enable.
    always_ff @(posedge g_clk) begin
        if (g_reset || clr_i) begin
            count_q <= 8'd0;
        end else if (en_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/scarv_cop_cpu_issue.sv
// CPU-side issue unit for the SCARV coprocessor: accepts one instruction from
// the pipeline, hands it over with req/ack, waits for the response (with a
// timeout) and holds the result until the pipeline consumes it.
module scarv_cop_cpu_issue
    import scarv_cop_cpu_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [31:0] pipe_enc,
    input  logic [31:0] pipe_rs1,
    input  logic        pipe_flush,

    output logic        cpu_insn_req,
    input  logic        cpu_insn_ack,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,

    input  logic        cop_insn_rsp,
    input  logic [2:0]  cop_insn_status,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_status,
    output logic        res_wen,
    output logic [4:0]  res_waddr,
    output logic [31:0] res_wdata,

    output logic        busy
);

    issue_state_e state_q;
    logic [31:0]  enc_q;
    logic [31:0]  rs1_q;
    logic [2:0]   res_status_q;
    logic         res_wen_q;
    logic [4:0]   res_waddr_q;
    logic [31:0]  res_wdata_q;

    logic         timer_clr;
    logic         timer_en;
    logic         timer_expired;

    assign timer_clr = (state_q == StReq) && cpu_insn_ack;
    assign timer_en  = (state_q == StWaitRsp);

    scarv_cop_issue_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Issue FSM together with the instruction and result holding registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q      <= StIdle;
            enc_q        <= 32'd0;
            rs1_q        <= 32'd0;
            res_status_q <= SCARV_COP_INSN_SUCCESS;
            res_wen_q    <= 1'b0;
            res_waddr_q  <= 5'd0;
            res_wdata_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pipe_valid && !pipe_flush) begin
                        enc_q   <= pipe_enc;
                        rs1_q   <= pipe_rs1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    // Ack wins over flush: once acknowledged the instruction is committed.
                    if (cpu_insn_ack) begin
                        if (cop_insn_rsp) begin
                            res_status_q <= cop_insn_status;
                            res_wen_q    <= mask_wen(cop_insn_status, cop_wen);
                            res_waddr_q  <= cop_waddr;
                            res_wdata_q  <= cop_wdata;
                            state_q      <= StDone;
                        end else begin
                            state_q <= StWaitRsp;
                        end
                    end else if (pipe_flush) begin
                        state_q <= StIdle;
                    end
                end
                StWaitRsp: begin
                    // A response in the expiry cycle still counts as a real response.
                    if (cop_insn_rsp) begin
                        res_status_q <= cop_insn_status;
                        res_wen_q    <= mask_wen(cop_insn_status, cop_wen);
                        res_waddr_q  <= cop_waddr;
                        res_wdata_q  <= cop_wdata;
                        state_q      <= StDone;
                    end else if (timer_expired) begin
                        res_status_q <= SCARV_COP_INSN_TIMEOUT;
                        res_wen_q    <= 1'b0;
                        res_waddr_q  <= 5'd0;
                        res_wdata_q  <= 32'd0;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // All handshake outputs decode registered state only.
    assign pipe_ready   = (state_q == StIdle);
    assign cpu_insn_req = (state_q == StReq);
    assign res_valid    = (state_q == StDone);
    assign busy         = (state_q != StIdle);

    assign cpu_insn_enc = enc_q;
    assign cpu_rs1      = rs1_q;
    assign res_status   = res_status_q;
    assign res_wen      = res_wen_q;
    assign res_waddr    = res_waddr_q;
    assign res_wdata    = res_wdata_q;

endmodule

// File: tb/tb_scarv_cop_cpu_issue.sv
// Directed bench for scarv_cop_cpu_issue: a vector table of single-cycle
// transactions plus hand-written sequences for stalls, flush, timeout,
// backpressure and reset in flight.
module tb_scarv_cop_cpu_issue;

    localparam int unsigned Tmo = 4;

    logic        g_clk;
    logic        g_reset;
    logic        pipe_valid;
    logic        pipe_ready;
    logic [31:0] pipe_enc;
    logic [31:0] pipe_rs1;
    logic        pipe_flush;
    logic        cpu_insn_req;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_insn_rsp;
    logic [2:0]  cop_insn_status;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_status;
    logic        res_wen;
    logic [4:0]  res_waddr;
    logic [31:0] res_wdata;
    logic        busy;

    int total;
    int bad;

    scarv_cop_cpu_issue #(
        .TIMEOUT (Tmo)
    ) dut (
        .g_clk           (g_clk),
        .g_reset         (g_reset),
        .pipe_valid      (pipe_valid),
        .pipe_ready      (pipe_ready),
        .pipe_enc        (pipe_enc),
        .pipe_rs1        (pipe_rs1),
        .pipe_flush      (pipe_flush),
        .cpu_insn_req    (cpu_insn_req),
        .cpu_insn_ack    (cpu_insn_ack),
        .cpu_insn_enc    (cpu_insn_enc),
        .cpu_rs1         (cpu_rs1),
        .cop_insn_rsp    (cop_insn_rsp),
        .cop_insn_status (cop_insn_status),
        .cop_wen         (cop_wen),
        .cop_waddr       (cop_waddr),
        .cop_wdata       (cop_wdata),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_status      (res_status),
        .res_wen         (res_wen),
        .res_waddr       (res_waddr),
        .res_wdata       (res_wdata),
        .busy            (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [31:0] enc;
        logic [31:0] rs1;
        logic [2:0]  st;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  exp_st;
        logic        exp_wen;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req"},   32'(cpu_insn_req), 32'd0);
        chk({tag, " enc"},   cpu_insn_enc, 32'd0);
        chk({tag, " rs1"},   cpu_rs1, 32'd0);
        chk({tag, " rv"},    32'(res_valid), 32'd0);
        chk({tag, " rst"},   32'(res_status), 32'd0);
        chk({tag, " rwen"},  32'(res_wen), 32'd0);
        chk({tag, " rwa"},   32'(res_waddr), 32'd0);
        chk({tag, " rwd"},   res_wdata, 32'd0);
        chk({tag, " busy"},  32'(busy), 32'd0);
        chk({tag, " prdy"},  32'(pipe_ready), 32'd1);
    endtask

    task automatic cop_idle();
        cpu_insn_ack    = 1'b0;
        cop_insn_rsp    = 1'b0;
        cop_insn_status = 3'd0;
        cop_wen         = 1'b0;
        cop_waddr       = 5'd0;
        cop_wdata       = 32'd0;
    endtask

    task automatic drive_rsp(input logic [2:0] st, input logic wen, input logic [4:0] wa,
                             input logic [31:0] wd);
        cop_insn_rsp    = 1'b1;
        cop_insn_status = st;
        cop_wen         = wen;
        cop_waddr       = wa;
        cop_wdata       = wd;
    endtask

    // Offer an instruction in IDLE; returns in cycle 1 with the request up.
    task automatic issue(input string tag, input logic [31:0] enc, input logic [31:0] rs1);
        pipe_valid = 1'b1;
        pipe_enc   = enc;
        pipe_rs1   = rs1;
        step();
        pipe_valid = 1'b0;
        pipe_enc   = 32'hFFFF_FFFF;
        pipe_rs1   = 32'hFFFF_FFFF;
        chk({tag, " req"},  32'(cpu_insn_req), 32'd1);
        chk({tag, " enc"},  cpu_insn_enc, enc);
        chk({tag, " rs1"},  cpu_rs1, rs1);
        chk({tag, " prdy"}, 32'(pipe_ready), 32'd0);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, " prdy after consume"}, 32'(pipe_ready), 32'd1);
        chk({tag, " rv after consume"},   32'(res_valid), 32'd0);
    endtask

    logic [2:0]  hold_st;
    logic        hold_wen;
    logic [4:0]  hold_wa;
    logic [31:0] hold_wd;

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{32'h1234_5677, 32'hDEAD_BEEF, 3'b000, 1'b1, 5'd5,  32'hA5A5_A5A5, 3'b000, 1'b1};
        vecs[1] = '{32'h0000_0001, 32'h0000_0002, 3'b010, 1'b1, 5'd7,  32'h1111_2222, 3'b010, 1'b0};
        vecs[2] = '{32'hFFFF_0000, 32'h8000_0001, 3'b000, 1'b0, 5'd31, 32'h0F0F_0F0F, 3'b000, 1'b0};
        vecs[3] = '{32'h5555_AAAA, 32'h0000_0000, 3'b111, 1'b1, 5'd1,  32'hFFFF_FFFF, 3'b111, 1'b0};
        vecs[4] = '{32'h0BAD_F00D, 32'h1357_9BDF, 3'b001, 1'b1, 5'd16, 32'h8765_4321, 3'b001, 1'b0};

        g_reset    = 1'b1;
        pipe_valid = 1'b0;
        pipe_enc   = 32'd0;
        pipe_rs1   = 32'd0;
        pipe_flush = 1'b0;
        res_ready  = 1'b0;
        cop_idle();
        step();
        step();
        chk_reset_vals("reset");
        g_reset = 1'b0;
        step();

        // Table: ack and rsp in cycle 1, result in cycle 2, ready in cycle 3.
        for (int i = 0; i < 5; i++) begin
            issue($sformatf("v%0d", i), vecs[i].enc, vecs[i].rs1);
            cpu_insn_ack = 1'b1;
            drive_rsp(vecs[i].st, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            step();
            cop_idle();
            chk($sformatf("v%0d rv", i),     32'(res_valid), 32'd1);
            chk($sformatf("v%0d req", i),    32'(cpu_insn_req), 32'd0);
            chk($sformatf("v%0d status", i), 32'(res_status), 32'(vecs[i].exp_st));
            chk($sformatf("v%0d wen", i),    32'(res_wen), 32'(vecs[i].exp_wen));
            chk($sformatf("v%0d waddr", i),  32'(res_waddr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d wdata", i),  res_wdata, vecs[i].wdata);
            consume($sformatf("v%0d", i));
        end

        // Stray ack in IDLE changes nothing.
        cpu_insn_ack = 1'b1;
        step();
        cpu_insn_ack = 1'b0;
        chk("idle ack req", 32'(cpu_insn_req), 32'd0);
        chk("idle ack prdy", 32'(pipe_ready), 32'd1);

        // Ack stall for 4 cycles; stray rsp and new pipe offers must not disturb REQ.
        issue("stall", 32'hCAFE_0001, 32'h0BAD_0001);
        for (int i = 0; i < 4; i++) begin
            pipe_valid = 1'b1;
            pipe_enc   = 32'h9999_0000 + 32'(i);
            if (i == 1) drive_rsp(3'b000, 1'b1, 5'd9, 32'h7777_7777);
            step();
            cop_idle();
            chk($sformatf("stall%0d req", i), 32'(cpu_insn_req), 32'd1);
            chk($sformatf("stall%0d enc", i), cpu_insn_enc, 32'hCAFE_0001);
            chk($sformatf("stall%0d rs1", i), cpu_rs1, 32'h0BAD_0001);
            chk($sformatf("stall%0d rv", i),  32'(res_valid), 32'd0);
        end
        pipe_valid   = 1'b0;
        cpu_insn_ack = 1'b1;
        step();
        cpu_insn_ack = 1'b0;
        chk("stall wait req", 32'(cpu_insn_req), 32'd0);
        chk("stall wait busy", 32'(busy), 32'd1);
        step();
        chk("stall wait rv", 32'(res_valid), 32'd0);
        drive_rsp(3'b000, 1'b1, 5'd12, 32'h0C0C_0C0C);
        step();
        cop_idle();
        chk("stall rsp rv", 32'(res_valid), 32'd1);
        chk("stall rsp wen", 32'(res_wen), 32'd1);
        chk("stall rsp waddr", 32'(res_waddr), 32'd12);
        chk("stall rsp wdata", res_wdata, 32'h0C0C_0C0C);
        consume("stall");

        // Flush in IDLE with valid: dropped.
        pipe_valid = 1'b1;
        pipe_flush = 1'b1;
        step();
        pipe_valid = 1'b0;
        pipe_flush = 1'b0;
        chk("idle flush req", 32'(cpu_insn_req), 32'd0);
        chk("idle flush prdy", 32'(pipe_ready), 32'd1);

        // Flush in REQ without ack: request dropped, no result.
        issue("flush", 32'h0F0F_0001, 32'h0000_00AA);
        pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;
        chk("flush req", 32'(cpu_insn_req), 32'd0);
        chk("flush prdy", 32'(pipe_ready), 32'd1);
        chk("flush busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush rv%0d", i), 32'(res_valid), 32'd0);
        end

        // Flush with ack proceeds; flush also ignored in WAIT_RSP and DONE.
        issue("fack", 32'h0F0F_0002, 32'h0000_00BB);
        pipe_flush   = 1'b1;
        cpu_insn_ack = 1'b1;
        step();
        cpu_insn_ack = 1'b0;
        chk("fack wait busy", 32'(busy), 32'd1);
        chk("fack wait req", 32'(cpu_insn_req), 32'd0);
        step();
        chk("fack wait2 busy", 32'(busy), 32'd1);
        drive_rsp(3'b000, 1'b1, 5'd3, 32'h0000_1111);
        step();
        cop_idle();
        chk("fack rv", 32'(res_valid), 32'd1);
        chk("fack wdata", res_wdata, 32'h0000_1111);
        step();
        chk("fack done hold", 32'(res_valid), 32'd1);
        pipe_flush = 1'b0;
        consume("fack");

        // Timeout: ack in cycle k, res_valid in cycle k+Tmo+1.
        issue("tmo", 32'h7000_0007, 32'h0000_0070);
        cpu_insn_ack = 1'b1;
        step();
        cpu_insn_ack = 1'b0;
        for (int i = 1; i <= int'(Tmo); i++) begin
            chk($sformatf("tmo rv k+%0d", i), 32'(res_valid), 32'd0);
            if (i < int'(Tmo)) step();
        end
        step();
        chk("tmo rv", 32'(res_valid), 32'd1);
        chk("tmo status", 32'(res_status), 32'd7);
        chk("tmo wen", 32'(res_wen), 32'd0);
        drive_rsp(3'b000, 1'b1, 5'd9, 32'h9999_9999);
        step();
        cop_idle();
        chk("tmo stray status", 32'(res_status), 32'd7);
        chk("tmo stray wen", 32'(res_wen), 32'd0);
        chk("tmo stray rv", 32'(res_valid), 32'd1);
        consume("tmo");
        drive_rsp(3'b000, 1'b1, 5'd9, 32'h9999_9999);
        step();
        cop_idle();
        chk("idle stray rv", 32'(res_valid), 32'd0);
        chk("idle stray status", 32'(res_status), 32'd7);

        // Error status with backpressure: result held, new instruction refused.
        issue("bp", 32'h2222_0002, 32'h3333_0003);
        cpu_insn_ack = 1'b1;
        drive_rsp(3'b010, 1'b1, 5'd21, 32'h4444_0004);
        step();
        cop_idle();
        hold_st  = 3'b010;
        hold_wen = 1'b0;
        hold_wa  = 5'd21;
        hold_wd  = 32'h4444_0004;
        for (int i = 0; i < 6; i++) begin
            pipe_valid = 1'b1;
            pipe_enc   = 32'h5000_0000 + 32'(i);
            chk($sformatf("bp%0d rv", i),     32'(res_valid), 32'd1);
            chk($sformatf("bp%0d status", i), 32'(res_status), 32'(hold_st));
            chk($sformatf("bp%0d wen", i),    32'(res_wen), 32'(hold_wen));
            chk($sformatf("bp%0d waddr", i),  32'(res_waddr), 32'(hold_wa));
            chk($sformatf("bp%0d wdata", i),  res_wdata, hold_wd);
            chk($sformatf("bp%0d prdy", i),   32'(pipe_ready), 32'd0);
            step();
            chk($sformatf("bp%0d req", i),    32'(cpu_insn_req), 32'd0);
        end
        pipe_valid = 1'b0;
        consume("bp");

        // Reset while waiting; a late response is ignored.
        issue("rst", 32'h6666_0006, 32'h7777_0007);
        cpu_insn_ack = 1'b1;
        step();
        cpu_insn_ack = 1'b0;
        chk("rst wait busy", 32'(busy), 32'd1);
        g_reset = 1'b1;
        step();
        g_reset = 1'b0;
        chk_reset_vals("midreset");
        drive_rsp(3'b000, 1'b1, 5'd2, 32'h2222_2222);
        step();
        cop_idle();
        chk("late rsp rv", 32'(res_valid), 32'd0);
        chk("late rsp wdata", res_wdata, 32'd0);
        step();
        chk("late rsp rv2", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
